// File: rtl/twodemux_stream.sv
// twodemux_stream: 1-to-2 stream demultiplexer with an independent FIFO per side.
// din_sel = 1 routes a beat to side A and din_sel = 0 routes it to side B. Each side
// buffers up to DEPTH beats, so a stalled consumer never blocks the other side.
// din_ready depends only on din_sel and FIFO occupancy. It never depends on din_valid
// or on the consumer readies, so no combinational ready path runs through the block.

// Single-clock FIFO. The caller may request a push while the FIFO is full; that push
// is dropped here as well. A pop while empty is ignored.
module twodemux_stream_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int OCCW = $clog2(DEPTH + 1);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam logic [OCCW-1:0] OCC_ONE  = OCCW'(1);
    localparam logic [OCCW-1:0] OCC_FULL = OCCW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCCW-1:0]  occ_q, occ_d;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (occ_q != '0);
    assign full_o  = (occ_q == OCC_FULL);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;
    // The head is forced to zero while empty so a stale entry is never visible.
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Next-state pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Pointer, occupancy and storage registers. Reset clears everything, including storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

module twodemux_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] douta,
    output logic             douta_valid,
    input  logic             douta_ready,
    output logic [WIDTH-1:0] doutb,
    output logic             doutb_valid,
    input  logic             doutb_ready,
    output logic [CNTW-1:0]  cnta,
    output logic [CNTW-1:0]  cntb
);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic            route_a, route_b;
    logic            full_a, full_b;
    logic            push_a, push_b;
    logic            pop_a, pop_b;
    logic [CNTW-1:0] cnta_q, cnta_d;
    logic [CNTW-1:0] cntb_q, cntb_d;

    // Decode the select. An unknown select matches neither side, so nothing is pushed.
    always_comb begin
        route_a = 1'b0;
        route_b = 1'b0;
        case (din_sel)
            1'b1:    route_a = 1'b1;
            1'b0:    route_b = 1'b1;
            default: begin
                route_a = 1'b0;
                route_b = 1'b0;
            end
        endcase
    end

    assign din_ready = ~rst & ((route_a & ~full_a) | (route_b & ~full_b));
    assign push_a    = din_valid & din_ready & route_a;
    assign push_b    = din_valid & din_ready & route_b;
    assign pop_a     = douta_valid & douta_ready;
    assign pop_b     = doutb_valid & doutb_ready;

    twodemux_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_a),
        .data_i  (din),
        .pop_i   (douta_ready),
        .full_o  (full_a),
        .valid_o (douta_valid),
        .head_o  (douta)
    );

    twodemux_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_b),
        .data_i  (din),
        .pop_i   (doutb_ready),
        .full_o  (full_b),
        .valid_o (doutb_valid),
        .head_o  (doutb)
    );

    // Next-state delivery counters. They wrap silently at 2^CNTW.
    always_comb begin
        cnta_d = cnta_q;
        cntb_d = cntb_q;
        if (pop_a) cnta_d = cnta_q + CNT_ONE;
        if (pop_b) cntb_d = cntb_q + CNT_ONE;
    end

    // Delivery counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnta_q <= '0;
            cntb_q <= '0;
        end else begin
            cnta_q <= cnta_d;
            cntb_q <= cntb_d;
        end
    end

    assign cnta = cnta_q;
    assign cntb = cntb_q;
endmodule

// File: tb/tb_twodemux_stream.sv
// Testbench for twodemux_stream: directed steps plus a short random phase.
// A negedge monitor keeps one expected queue per side. It compares every DUT output
// against that model and then applies the handshakes that will occur on the next edge.
module tb_twodemux_stream;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNTW  = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_sel;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] douta;
  logic             douta_valid;
  logic             douta_ready;
  logic [WIDTH-1:0] doutb;
  logic             doutb_valid;
  logic             doutb_ready;
  logic [CNTW-1:0]  cnta;
  logic [CNTW-1:0]  cntb;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_a_q[$];
  logic [WIDTH-1:0] exp_b_q[$];
  logic [CNTW-1:0]  cnt_a_exp = '0;
  logic [CNTW-1:0]  cnt_b_exp = '0;

  twodemux_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_sel     (din_sel),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .douta       (douta),
    .douta_valid (douta_valid),
    .douta_ready (douta_ready),
    .doutb       (doutb),
    .doutb_valid (doutb_valid),
    .doutb_ready (doutb_ready),
    .cnta        (cnta),
    .cntb        (cntb)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  // scoreboard monitor: compare the current outputs, then commit the upcoming handshakes
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst) begin
      exp_a_q.delete();
      exp_b_q.delete();
      cnt_a_exp = '0;
      cnt_b_exp = '0;
      check("rst_din_ready", 32'(din_ready), 32'd0);
      check("rst_douta_valid", 32'(douta_valid), 32'd0);
      check("rst_doutb_valid", 32'(doutb_valid), 32'd0);
      check("rst_douta", 32'(douta), 32'd0);
      check("rst_doutb", 32'(doutb), 32'd0);
      check("rst_cnta", 32'(cnta), 32'd0);
      check("rst_cntb", 32'(cntb), 32'd0);
    end else begin
      exp_rdy = din_sel ? (exp_a_q.size() < DEPTH) : (exp_b_q.size() < DEPTH);
      check("din_ready", 32'(din_ready), 32'(exp_rdy));
      check("douta_valid", 32'(douta_valid), 32'(exp_a_q.size() != 0));
      check("doutb_valid", 32'(doutb_valid), 32'(exp_b_q.size() != 0));
      check("douta", 32'(douta), (exp_a_q.size() != 0) ? 32'(exp_a_q[0]) : 32'd0);
      check("doutb", 32'(doutb), (exp_b_q.size() != 0) ? 32'(exp_b_q[0]) : 32'd0);
      check("cnta", 32'(cnta), 32'(cnt_a_exp));
      check("cntb", 32'(cntb), 32'(cnt_b_exp));
      // Readiness and pops are both based on the pre-edge state.
      if (douta_ready && exp_a_q.size() != 0) begin
        void'(exp_a_q.pop_front());
        cnt_a_exp = cnt_a_exp + 1'b1;
      end
      if (doutb_ready && exp_b_q.size() != 0) begin
        void'(exp_b_q.pop_front());
        cnt_b_exp = cnt_b_exp + 1'b1;
      end
      if (din_valid && exp_rdy) begin
        if (din_sel) exp_a_q.push_back(din);
        else exp_b_q.push_back(din);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] data, input logic sel);
    logic acc;
    int   n;
    din       = data;
    din_sel   = sel;
    din_valid = 1'b1;
    n         = 0;
    do begin
      @(negedge clk);
      acc = din_ready;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) fail_timeout("send_accept");
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) fail_timeout("drain");
    step();
  endtask

  initial begin
    rst         = 1'b1;
    din         = '0;
    din_sel     = 1'b0;
    din_valid   = 1'b0;
    douta_ready = 1'b0;
    doutb_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset release: ready for both sides
    din_sel = 1'b1;
    @(negedge clk);
    check("release_ready_a", 32'(din_ready), 32'd1);
    step();
    din_sel = 1'b0;
    @(negedge clk);
    check("release_ready_b", 32'(din_ready), 32'd1);
    step();

    // Routing
    douta_ready = 1'b1;
    doutb_ready = 1'b1;
    send(4'hA, 1'b1);
    send(4'h5, 1'b0);
    drain();
    check("route_cnta", 32'(cnta), 32'd1);
    check("route_cntb", 32'(cntb), 32'd1);

    // Backpressure on A; B stays open
    douta_ready = 1'b0;
    send(4'h3, 1'b1);
    send(4'h6, 1'b1);
    din       = 4'h9;
    din_sel   = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    check("bp_ready_a_full", 32'(din_ready), 32'd0);
    step();
    din_valid = 1'b0;
    din_sel   = 1'b0;
    @(negedge clk);
    check("bp_ready_b_open", 32'(din_ready), 32'd1);
    check("bp_head_a", 32'(douta), 32'h3);
    step();

    // Full with pop: the push is refused this cycle and accepted the next
    din         = 4'h9;
    din_sel     = 1'b1;
    din_valid   = 1'b1;
    douta_ready = 1'b1;
    @(negedge clk);
    check("fullpop_refused", 32'(din_ready), 32'd0);
    step();
    @(negedge clk);
    check("fullpop_accept_next", 32'(din_ready), 32'd1);
    check("fullpop_head_a", 32'(douta), 32'h6);
    step();
    din_valid = 1'b0;
    drain();
    check("bp_cnta", 32'(cnta), 32'd4);
    check("bp_cntb", 32'(cntb), 32'd1);

    // Random mixed traffic
    for (int i = 0; i < 300; i++) begin
      din         = WIDTH'($urandom_range(0, 15));
      din_sel     = 1'($urandom_range(0, 1));
      din_valid   = 1'($urandom_range(0, 1));
      douta_ready = ($urandom_range(0, 3) != 0);
      doutb_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    din_valid   = 1'b0;
    douta_ready = 1'b1;
    doutb_ready = 1'b1;
    drain();

    // Reset mid-stream with two beats held on A
    douta_ready = 1'b0;
    send(4'h1, 1'b1);
    send(4'h2, 1'b1);
    @(negedge clk);
    check("pre_rst_douta_valid", 32'(douta_valid), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_douta_valid", 32'(douta_valid), 32'd0);
    check("async_rst_douta", 32'(douta), 32'd0);
    check("async_rst_cnta", 32'(cnta), 32'd0);
    check("async_rst_din_ready", 32'(din_ready), 32'd0);
    step();
    rst         = 1'b0;
    douta_ready = 1'b1;
    @(negedge clk);
    check("post_rst_douta_valid", 32'(douta_valid), 32'd0);
    check("post_rst_douta", 32'(douta), 32'd0);
    check("post_rst_cnta", 32'(cnta), 32'd0);
    check("post_rst_din_ready", 32'(din_ready), 32'd1);
    step();

    // Counter wrap: 256 deliveries on B
    doutb_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(WIDTH'($urandom_range(0, 15)), 1'b0);
    end
    drain();
    check("wrap_cntb", 32'(cntb), 32'd0);
    check("wrap_cnta", 32'(cnta), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
